// File: rtl/cmd_bus_arbiter.sv
// Round-robin arbiter sharing one downstream command bus among NUM_REQ requesters.
// Latches single-cycle strobes into per-requester slots and routes ack/rdata/timeout back.
module cmd_bus_arbiter #(
  parameter int unsigned NUM_REQ              = 4,
  parameter int unsigned ADDR_BITS            = 24,
  parameter int unsigned DATA_BITS            = 32,
  parameter int unsigned P_GRANT_TIMEOUT_CLKS = 64
) (
  input  logic                           i_sysclk,
  input  logic                           i_srst_n,
  input  logic [NUM_REQ-1:0]             i_req_sel,
  input  logic [NUM_REQ-1:0]             i_req_rd_wr_n,
  input  logic [NUM_REQ*ADDR_BITS-1:0]   i_req_byte_addr,
  input  logic [NUM_REQ*DATA_BITS-1:0]   i_req_wdata,
  output logic [NUM_REQ-1:0]             o_req_busy,
  output logic [NUM_REQ-1:0]             o_req_ack,
  output logic [NUM_REQ-1:0]             o_req_timeout,
  output logic [NUM_REQ-1:0]             o_req_drop,
  output logic [DATA_BITS-1:0]           o_req_rdata,
  output logic                           o_cmd_sel,
  output logic                           o_cmd_rd_wr_n,
  output logic [ADDR_BITS-1:0]           o_cmd_byte_addr,
  output logic [DATA_BITS-1:0]           o_cmd_wdata,
  input  logic                           i_cmd_ack,
  input  logic [DATA_BITS-1:0]           i_cmd_rdata,
  input  logic                           i_cmd_timeout
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned WD_W  = $clog2(P_GRANT_TIMEOUT_CLKS + 1);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(P_GRANT_TIMEOUT_CLKS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                 state_q, state_d;
  logic [NUM_REQ-1:0]     slot_rd;
  logic [ADDR_BITS-1:0]   slot_addr  [NUM_REQ];
  logic [DATA_BITS-1:0]   slot_wdata [NUM_REQ];
  logic [IDX_W-1:0]       rr_q, gnt_q, pick_c, rr_next_c;
  logic                   pick_vld_c;
  int unsigned            idx_c;
  logic [WD_W-1:0]        wd_q;
  logic                   grant_c, done_ack_c, done_to_c;

  // First pending slot at or after the round-robin pointer, with wrap.
  always_comb begin
    pick_c     = '0;
    pick_vld_c = 1'b0;
    idx_c      = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx_c = 32'(rr_q) + i;
      if (idx_c >= NUM_REQ) idx_c = idx_c - NUM_REQ;
      if (!pick_vld_c && o_req_busy[IDX_W'(idx_c)]) begin
        pick_c     = IDX_W'(idx_c);
        pick_vld_c = 1'b1;
      end
    end
  end

  assign rr_next_c = (pick_c == IDX_LAST) ? '0 : pick_c + IDX_W'(1);

  always_ff @(posedge i_sysclk) begin
    if (!i_srst_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Ack outranks downstream timeout, which outranks the watchdog.
  always_comb begin
    state_d    = state_q;
    grant_c    = 1'b0;
    done_ack_c = 1'b0;
    done_to_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_vld_c) begin
          grant_c = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (i_cmd_ack) begin
          done_ack_c = 1'b1;
          state_d    = IDLE;
        end else if (i_cmd_timeout || (wd_q == WD_LAST)) begin
          done_to_c = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_sysclk) begin
    if (!i_srst_n) begin
      o_req_busy      <= '0;
      o_req_ack       <= '0;
      o_req_timeout   <= '0;
      o_req_drop      <= '0;
      o_req_rdata     <= '0;
      o_cmd_sel       <= 1'b0;
      o_cmd_rd_wr_n   <= 1'b0;
      o_cmd_byte_addr <= '0;
      o_cmd_wdata     <= '0;
      rr_q            <= '0;
      gnt_q           <= '0;
      wd_q            <= '0;
      slot_rd         <= '0;
      for (int r = 0; r < NUM_REQ; r++) begin
        slot_addr[r]  <= '0;
        slot_wdata[r] <= '0;
      end
    end else begin
      o_req_ack     <= '0;
      o_req_timeout <= '0;
      o_cmd_sel     <= 1'b0;

      // A slot owner is busy until completion, so set and clear never collide.
      for (int r = 0; r < NUM_REQ; r++) begin
        if (i_req_sel[r]) begin
          if (o_req_busy[r]) begin
            o_req_drop[r] <= 1'b1;
          end else begin
            o_req_busy[r] <= 1'b1;
            slot_rd[r]    <= i_req_rd_wr_n[r];
            slot_addr[r]  <= i_req_byte_addr[r*ADDR_BITS +: ADDR_BITS];
            slot_wdata[r] <= i_req_wdata[r*DATA_BITS +: DATA_BITS];
          end
        end
      end

      if (grant_c) begin
        o_cmd_sel       <= 1'b1;
        o_cmd_rd_wr_n   <= slot_rd[pick_c];
        o_cmd_byte_addr <= slot_addr[pick_c];
        o_cmd_wdata     <= slot_wdata[pick_c];
        gnt_q           <= pick_c;
        rr_q            <= rr_next_c;
      end

      if (state_q == ISSUE) begin
        wd_q <= '0;
      end else if ((state_q == WAIT) && (wd_q != WD_LAST)) begin
        wd_q <= wd_q + WD_W'(1);
      end

      if (done_ack_c) begin
        o_req_ack[gnt_q]  <= 1'b1;
        o_req_rdata       <= i_cmd_rdata;
        o_req_busy[gnt_q] <= 1'b0;
      end
      if (done_to_c) begin
        o_req_timeout[gnt_q] <= 1'b1;
        o_req_busy[gnt_q]    <= 1'b0;
      end
    end
  end

endmodule
